sat_step_arbiter: RTL and testbench
===================================

# sat_step_arbiter

Arbitrates increment/decrement requests from several requesters (debounced buttons, protocol command decoders) onto the single pair of step pulses driving the shared saturating register. Grants requests round-robin, issues exactly one single-cycle step per grant, and rejects steps that would push the register past its limits. It enforces a minimum gap between steps so the register output has settled before the next limit check. The block sits between the debounce/command front-ends and the saturation register, alongside the LED controller.

## Interface
- `NREQ`, 3: number of requesters, 2..8.
- `WIDTH`, 4: saturation register width parameter; the register value is `WIDTH+1` bits.
- `GAP`, 2: idle cycles after each grant before the next arbitration, 1..15.

- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req`  in  NREQ  per-requester request level.
- `dir`  in  NREQ  per-requester direction: 1 = increase, 0 = decrease. Must be stable while the matching `req` bit is high.
- `value`  in  WIDTH+1  current saturation register value.
- `ack`  out  NREQ  one-hot, one-cycle pulse: step issued for that requester.
- `rej`  out  NREQ  one-hot, one-cycle pulse: step refused because the register is at its limit.
- `inc_pulse`  out  1  one-cycle increase strobe to the saturation register.
- `dec_pulse`  out  1  one-cycle decrease strobe to the saturation register.
- `busy`  out  1  high in ISSUE and WAIT states.
- `grant_id`  out  clog2(NREQ)  index of the last granted requester; holds its value between grants.

## Operation
- Limits:
  - MAX = 2^(WIDTH+1)−1.
  - MIN = 0.
  - `value` is compared unsigned at full WIDTH+1 width.
- State machine:
  - **IDLE**: if `req` is non-zero, select the winner round-robin starting at `ptr`. Latch the winner's index and `dir`, and evaluate the limit check against `value` in this cycle. Go to ISSUE. If `req` is zero, stay in IDLE.
  - **ISSUE** (1 cycle):
    - If the latched step is allowed, assert `ack[id]` and either `inc_pulse` or `dec_pulse`.
    - If it is refused (inc with `value`==MAX, or dec with `value`==0), assert `rej[id]` and no strobe.
    - Load the gap counter with `GAP` and set `ptr` = (id+1) mod NREQ. Go to WAIT.
  - **WAIT**: decrement the gap counter; go to IDLE when it reaches 0. While in WAIT, `req` is ignored (not latched, not lost; it is still a level).
- Handshake:
  - A requester holds `req` until it sees `ack` or `rej`, and drops `req` on the edge that ends that pulse.
  - A `req` dropped before grant is a withdrawal, with no side effects.
  - A `req` still high when the block returns to IDLE counts as a new request; this is the auto-repeat behaviour.
- Refused steps also advance `ptr`, so a requester stuck at a limit cannot starve others.
- `ack`, `rej`, `inc_pulse` and `dec_pulse` are registered outputs and never high simultaneously for the same requester. `inc_pulse` and `dec_pulse` are mutually exclusive.
- Reset (asynchronous, any state): state = IDLE, `ptr` = 0, `grant_id` = 0, gap counter = 0, and `ack`, `rej`, `inc_pulse`, `dec_pulse`, `busy` = 0. A step pending at reset is dropped. No strobe may glitch high on reset release.

## Timing
- Grant latency: `req` high at IDLE edge N gives ack/rej and strobe high during cycle N+1.
- Issue throughput: one step per GAP+2 cycles, i.e. 4 cycles at GAP=2.
- The limit check uses `value` sampled at edge N. GAP ≥ 1 guarantees that the saturation register has absorbed the previous strobe before the next check.
- `busy` rises with ISSUE and falls on entry to IDLE.

## Structure
- Shared package `sat_pkg` holds:
  - state encoding (IDLE, ISSUE, WAIT);
  - the DIR_INC / DIR_DEC constants;
  - a function returning MAX for a given WIDTH.
- Sub-module `rr_pick`: combinational round-robin priority selector with inputs `req` and `ptr`, outputs one-hot `win` and `win_id`. Instantiated once.
- Gap counter, limit compare and FSM live in the top module.

## Test plan
- Reset mid-WAIT: assert `rst_n`=0 during WAIT → all outputs are 0 immediately. After release with `req`=0, the block stays in IDLE and `ptr`=0.
- Single requester, WIDTH=4, `value`=5, `req[0]`=1, `dir[0]`=1 → `ack[0]` and `inc_pulse` high exactly one cycle, in cycle N+1. `busy` is high for 1+GAP cycles.
- Upper limit: `value`=31, inc request from requester 1 → `rej[1]`=1 and `inc_pulse` stays 0. Lower limit: `value`=0, dec request → `rej`, no `dec_pulse`.
- Round-robin: `req`=3'b111 held continuously, with each requester re-raising `req` after its ack/rej → grants in order 0,1,2,0. Successive strobes are exactly 4 cycles apart (GAP=2). `grant_id` tracks each grant.
- Mixed directions: requester 0 increases, requester 2 decreases, both held with `value`=10 → strobes alternate inc,dec. `value` returns to 10 after each pair, and `inc_pulse`/`dec_pulse` are never both high.
- Withdrawal: `req[1]` pulsed high only during WAIT → no `ack[1]`, no `rej[1]`, no strobe.

Source files
------------

// File: rtl/sat_pkg.sv
// Shared definitions for the saturating-register step arbiter.
package sat_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_e;

  localparam logic DIR_INC = 1'b1;
  localparam logic DIR_DEC = 1'b0;

  localparam int GAP_W = 4;

  // Largest value held by a saturation register of WIDTH+1 bits.
  function automatic logic [31:0] sat_max(input int unsigned width);
    sat_max = (32'd1 << (width + 32'd1)) - 32'd1;
  endfunction

endpackage

// File: rtl/sat_step_arbiter_rr_pick.sv
// Combinational round-robin selector: first asserted request at or after ptr,
// wrapping modulo NREQ.
module rr_pick
  import sat_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] win,
  output logic [IDW-1:0]  win_id
);

  localparam int CW = IDW + 1;

  logic          found_s;
  logic [CW-1:0] cand_s;

  // Scan candidates in priority order ptr, ptr+1, ... and keep the first hit.
  always_comb begin
    win     = '0;
    win_id  = '0;
    found_s = 1'b0;
    cand_s  = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand_s = CW'(ptr) + CW'(i);
      if (cand_s >= CW'(NREQ)) begin
        cand_s = cand_s - CW'(NREQ);
      end else begin
        cand_s = cand_s;
      end
      for (int j = 0; j < NREQ; j++) begin
        if (!found_s && (cand_s == CW'(j)) && req[j]) begin
          win[j]  = 1'b1;
          win_id  = IDW'(j);
          found_s = 1'b1;
        end else begin
          found_s = found_s;
        end
      end
    end
  end

endmodule

// File: rtl/sat_step_arbiter.sv
// Round-robin arbiter turning requester inc/dec requests into single-cycle
// step strobes for a shared saturating register, with limit rejection and gap.
module sat_step_arbiter
  import sat_pkg::*;
#(
  parameter int NREQ  = 3,
  parameter int WIDTH = 4,
  parameter int GAP   = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ-1:0]          dir,
  input  logic [WIDTH:0]           value,
  output logic [NREQ-1:0]          ack,
  output logic [NREQ-1:0]          rej,
  output logic                     inc_pulse,
  output logic                     dec_pulse,
  output logic                     busy,
  output logic [$clog2(NREQ)-1:0]  grant_id
);

  localparam int IDW = $clog2(NREQ);
  localparam int VW  = WIDTH + 1;

  localparam logic [VW-1:0]    MAX_VAL = VW'(sat_max(WIDTH));
  localparam logic [VW-1:0]    MIN_VAL = {VW{1'b0}};
  localparam logic [GAP_W-1:0] GAP_LD  = GAP_W'(GAP);
  localparam logic [GAP_W-1:0] GAP_ONE = GAP_W'(1);
  localparam logic [IDW-1:0]   LAST_ID = IDW'(NREQ - 1);
  localparam logic [IDW-1:0]   ID_ONE  = IDW'(1);

  state_e            state_r, state_nxt_s;
  logic [IDW-1:0]    ptr_r, ptr_nxt_s;
  logic [IDW-1:0]    grant_id_r, gid_nxt_s;
  logic [GAP_W-1:0]  gap_r, gap_nxt_s;
  logic [NREQ-1:0]   ack_r, ack_nxt_s;
  logic [NREQ-1:0]   rej_r, rej_nxt_s;
  logic              inc_r, inc_nxt_s;
  logic              dec_r, dec_nxt_s;
  logic              busy_r;

  logic [NREQ-1:0]   win_s;
  logic [IDW-1:0]    win_id_s;
  logic              win_dir_s;
  logic              step_ok_s;

  rr_pick #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_pick (
    .req    (req),
    .ptr    (ptr_r),
    .win    (win_s),
    .win_id (win_id_s)
  );

  assign win_dir_s = (|(dir & win_s)) == DIR_INC;
  // The limit check uses the register value seen on the arbitration edge.
  assign step_ok_s = win_dir_s ? (value != MAX_VAL) : (value != MIN_VAL);

  // Next-state and next-output decode for the arbitration FSM.
  always_comb begin
    state_nxt_s = state_r;
    ptr_nxt_s   = ptr_r;
    gid_nxt_s   = grant_id_r;
    gap_nxt_s   = gap_r;
    ack_nxt_s   = '0;
    rej_nxt_s   = '0;
    inc_nxt_s   = 1'b0;
    dec_nxt_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (|req) begin
          state_nxt_s = ST_ISSUE;
          gid_nxt_s   = win_id_s;
          if (step_ok_s) begin
            ack_nxt_s = win_s;
            inc_nxt_s = win_dir_s;
            dec_nxt_s = ~win_dir_s;
          end else begin
            rej_nxt_s = win_s;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        gap_nxt_s   = GAP_LD;
        ptr_nxt_s   = (grant_id_r == LAST_ID) ? {IDW{1'b0}} : (grant_id_r + ID_ONE);
        state_nxt_s = ST_WAIT;
      end
      ST_WAIT: begin
        if (gap_r <= GAP_ONE) begin
          gap_nxt_s   = {GAP_W{1'b0}};
          state_nxt_s = ST_IDLE;
        end else begin
          gap_nxt_s   = gap_r - GAP_ONE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State, pointer, counter and registered output flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      ptr_r      <= {IDW{1'b0}};
      grant_id_r <= {IDW{1'b0}};
      gap_r      <= {GAP_W{1'b0}};
      ack_r      <= {NREQ{1'b0}};
      rej_r      <= {NREQ{1'b0}};
      inc_r      <= 1'b0;
      dec_r      <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      ptr_r      <= ptr_nxt_s;
      grant_id_r <= gid_nxt_s;
      gap_r      <= gap_nxt_s;
      ack_r      <= ack_nxt_s;
      rej_r      <= rej_nxt_s;
      inc_r      <= inc_nxt_s;
      dec_r      <= dec_nxt_s;
      busy_r     <= (state_nxt_s != ST_IDLE);
    end
  end

  assign ack       = ack_r;
  assign rej       = rej_r;
  assign inc_pulse = inc_r;
  assign dec_pulse = dec_r;
  assign busy      = busy_r;
  assign grant_id  = grant_id_r;

endmodule

// File: tb/tb_sat_step_arbiter.sv
// Directed self-checking bench for sat_step_arbiter (NREQ=3, WIDTH=4, GAP=2).
module tb_sat_step_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] req, dir;
  logic [4:0] value_drv, sat_val, value_s;
  logic       model_en;
  logic [2:0] ack, rej;
  logic       inc_pulse, dec_pulse, busy;
  logic [1:0] grant_id;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [2:0] req;
    logic [2:0] dir;
    logic [4:0] val;
    logic [2:0] ack;
    logic [2:0] rej;
    logic       inc;
    logic       dec;
    logic       busy;
    logic [1:0] gid;
  } vec_t;

  vec_t vecs[11];

  always #5 clk = ~clk;

  assign value_s = model_en ? sat_val : value_drv;

  // External saturating register driven by the strobes when the model is on.
  always @(posedge clk) begin
    if (!model_en) sat_val <= value_drv;
    else if (inc_pulse && sat_val != 5'd31) sat_val <= sat_val + 5'd1;
    else if (dec_pulse && sat_val != 5'd0) sat_val <= sat_val - 5'd1;
  end

  sat_step_arbiter #(.NREQ(3), .WIDTH(4), .GAP(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .dir       (dir),
    .value     (value_s),
    .ack       (ack),
    .rej       (rej),
    .inc_pulse (inc_pulse),
    .dec_pulse (dec_pulse),
    .busy      (busy),
    .grant_id  (grant_id)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req   = 3'b000;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic int oh2id(input logic [2:0] v);
    case (v)
      3'b001:  return 0;
      3'b010:  return 1;
      3'b100:  return 2;
      default: return 3;
    endcase
  endfunction

  int ids[4], cyc_at[4], gids[4];
  int n, cyc, busy_cnt, ack_cnt, inc_cnt, seen, both_hi, seq_n;
  logic seq[4];
  logic pair_chk;

  initial begin
    // req, dir, value -> ack, rej, inc, dec, busy, grant_id  (ptr starts at 0)
    vecs[0]  = '{3'b001, 3'b001, 5'd5,  3'b001, 3'b000, 1'b1, 1'b0, 1'b1, 2'd0};
    vecs[1]  = '{3'b010, 3'b010, 5'd31, 3'b000, 3'b010, 1'b0, 1'b0, 1'b1, 2'd1};
    vecs[2]  = '{3'b100, 3'b000, 5'd0,  3'b000, 3'b100, 1'b0, 1'b0, 1'b1, 2'd2};
    vecs[3]  = '{3'b111, 3'b000, 5'd10, 3'b001, 3'b000, 1'b0, 1'b1, 1'b1, 2'd0};
    vecs[4]  = '{3'b101, 3'b101, 5'd7,  3'b100, 3'b000, 1'b1, 1'b0, 1'b1, 2'd2};
    vecs[5]  = '{3'b110, 3'b000, 5'd1,  3'b010, 3'b000, 1'b0, 1'b1, 1'b1, 2'd1};
    vecs[6]  = '{3'b011, 3'b011, 5'd30, 3'b001, 3'b000, 1'b1, 1'b0, 1'b1, 2'd0};
    vecs[7]  = '{3'b001, 3'b000, 5'd31, 3'b001, 3'b000, 1'b0, 1'b1, 1'b1, 2'd0};
    vecs[8]  = '{3'b100, 3'b100, 5'd0,  3'b100, 3'b000, 1'b1, 1'b0, 1'b1, 2'd2};
    vecs[9]  = '{3'b000, 3'b000, 5'd9,  3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 2'd2};
    vecs[10] = '{3'b010, 3'b000, 5'd16, 3'b010, 3'b000, 1'b0, 1'b1, 1'b1, 2'd1};

    rst_n = 1'b0; req = 3'b000; dir = 3'b000; value_drv = 5'd10; model_en = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset.outs", {29'd0, ack, rej, inc_pulse, dec_pulse, busy, grant_id}, 32'd0);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1 chk("reset.release", {29'd0, ack, rej, inc_pulse, dec_pulse, busy, grant_id}, 32'd0);

    // Round-robin with all three requesters held.
    @(negedge clk); req = 3'b111; dir = 3'b111; value_drv = 5'd10;
    n = 0; cyc = 0;
    for (int c = 0; c < 40 && n < 4; c++) begin
      @(posedge clk); #1; cyc++;
      if (|ack) begin
        ids[n] = oh2id(ack); cyc_at[n] = cyc; gids[n] = int'(grant_id); n++;
      end
    end
    req = 3'b000;
    chk("rr.count", n, 4);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("rr.id%0d", k), ids[k], (k == 3) ? 0 : k);
      chk($sformatf("rr.gid%0d", k), gids[k], (k == 3) ? 0 : k);
      if (k > 0) chk($sformatf("rr.gap%0d", k), cyc_at[k] - cyc_at[k-1], 4);
    end

    // Mixed directions driving the register model from 10.
    value_drv = 5'd10;
    do_reset();
    @(negedge clk); model_en = 1'b1; req = 3'b101; dir = 3'b001;
    seq_n = 0; both_hi = 0; pair_chk = 1'b0;
    for (int c = 0; c < 40 && seq_n < 4; c++) begin
      @(posedge clk); #1;
      if (pair_chk) begin chk("mix.value", sat_val, 5'd10); pair_chk = 1'b0; end
      if (inc_pulse && dec_pulse) both_hi++;
      if (inc_pulse) begin seq[seq_n] = 1'b1; seq_n++; end
      else if (dec_pulse) begin
        seq[seq_n] = 1'b0; seq_n++;
        if (seq_n % 2 == 0) pair_chk = 1'b1;
      end
    end
    @(posedge clk); #1;
    if (pair_chk) chk("mix.value", sat_val, 5'd10);
    chk("mix.count", seq_n, 4);
    chk("mix.order", {28'd0, seq[0], seq[1], seq[2], seq[3]}, 32'b1010);
    chk("mix.both_hi", both_hi, 0);
    @(negedge clk); req = 3'b000; model_en = 1'b0;

    // Table of single-grant transactions.
    do_reset();
    for (int k = 0; k < 11; k++) begin
      @(negedge clk); req = vecs[k].req; dir = vecs[k].dir; value_drv = vecs[k].val;
      @(posedge clk); #1;
      chk($sformatf("vec%0d.ack", k), ack, vecs[k].ack);
      chk($sformatf("vec%0d.rej", k), rej, vecs[k].rej);
      chk($sformatf("vec%0d.inc", k), inc_pulse, vecs[k].inc);
      chk($sformatf("vec%0d.dec", k), dec_pulse, vecs[k].dec);
      chk($sformatf("vec%0d.busy", k), busy, vecs[k].busy);
      chk($sformatf("vec%0d.gid", k), grant_id, vecs[k].gid);
      @(negedge clk); req = 3'b000;
      repeat (3) @(posedge clk);
      #1 chk($sformatf("vec%0d.idle", k), busy, 1'b0);
    end

    // Single requester latency, pulse width and busy length.
    @(negedge clk); req = 3'b001; dir = 3'b001; value_drv = 5'd5;
    #1 chk("single.pre", {ack, inc_pulse}, 4'b0000);
    @(posedge clk); #1;
    chk("single.ack", ack, 3'b001);
    chk("single.inc", {inc_pulse, dec_pulse}, 2'b10);
    busy_cnt = int'(busy); ack_cnt = int'(ack[0]); inc_cnt = int'(inc_pulse);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk); req = 3'b000;
      @(posedge clk); #1;
      busy_cnt += int'(busy); ack_cnt += int'(ack[0]); inc_cnt += int'(inc_pulse);
    end
    chk("single.busy_len", busy_cnt, 3);
    chk("single.ack_len", ack_cnt, 1);
    chk("single.inc_len", inc_cnt, 1);

    // Withdrawal: req[1] raised only while the block is in WAIT.
    do_reset();
    @(negedge clk); req = 3'b001; dir = 3'b001; value_drv = 5'd5;
    @(posedge clk); #1 chk("wd.ack0", ack, 3'b001);
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk); req = (c == 1) ? 3'b010 : 3'b000;
      @(posedge clk); #1;
      if ((|ack) || (|rej) || inc_pulse || dec_pulse) seen++;
    end
    chk("wd.none", seen, 0);

    // Asynchronous reset while in WAIT.
    @(negedge clk); req = 3'b100; dir = 3'b100; value_drv = 5'd5;
    @(posedge clk); #1 chk("rstw.gid", grant_id, 2'd2);
    @(negedge clk); req = 3'b000;
    @(posedge clk); #3;
    chk("rstw.busy_before", busy, 1'b1);
    rst_n = 1'b0;
    #1 chk("rstw.outs", {29'd0, ack, rej, inc_pulse, dec_pulse, busy, grant_id}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      if (busy || inc_pulse || dec_pulse || (|ack) || (|rej)) seen++;
    end
    chk("rstw.quiet", seen, 0);
    @(negedge clk); req = 3'b111; dir = 3'b111; value_drv = 5'd5;
    @(posedge clk); #1;
    chk("rstw.ptr_ack", ack, 3'b001);
    chk("rstw.ptr_gid", grant_id, 2'd0);
    @(negedge clk); req = 3'b000;
    repeat (4) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
